// File: rtl/shift_register_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load, plus an
// auto-shift sequencer with busy/done handshake. Optional rotate mode under SHIFT_ROTATE_EN.
module shift_register_univ #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
`ifdef SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dir_q, dir_nx;
  logic [WIDTH-1:0] q_nx, shifted;
  logic             dir_sel, rot_sel;
  logic             accept;

  assign accept = (state == S_IDLE) && start && (count != '0);

`ifdef SHIFT_ROTATE_EN
  logic rot_q;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                rot_q <= 1'b0;
    else if (enable && accept) rot_q <= rotate;
  end
  assign rot_sel = (state == S_SHIFT) ? rot_q : rotate;
`else
  assign rot_sel = 1'b0;
`endif

  // Manual ops use mode[1] as direction (01 right, 10 left); auto shifts use the latched dir.
  assign dir_sel = (state == S_SHIFT) ? dir_q : mode[1];

  always_comb begin
    shifted = q;
    if (dir_sel) shifted = {q[WIDTH-2:0], rot_sel ? q[WIDTH-1] : ser_in_l};
    else         shifted = {rot_sel ? q[0] : ser_in_r, q[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    q_nx     = q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_nx = S_SHIFT;
            cnt_nx   = count;
            dir_nx   = dir;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          case (mode)
            2'b01, 2'b10: q_nx = shifted;
            2'b11:        q_nx = par_in;
            default:      q_nx = q;
          endcase
        end
      end
      S_SHIFT: begin
        q_nx   = shifted;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
      q     <= '0;
    end else if (enable) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dir_q <= dir_nx;
      q     <= q_nx;
    end
  end

  // Status decodes straight from state, so a stalled clock holds busy/done too.
  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign ser_out_r = q[0];
  assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_univ.sv
// Bench for shift_register_univ: vector table, hand-written stall/abort/rotate
// sequences, and randomized traffic against a behavioural model.
module tb_shift_register_univ;
  localparam int W  = 4;
  localparam int CW = 4;

  logic          clock = 1'b0, clear = 1'b0, enable = 1'b0;
  logic [1:0]    mode = '0;
  logic          ser_in_r = 1'b0, ser_in_l = 1'b0;
  logic [W-1:0]  par_in = '0;
  logic          start = 1'b0, dir = 1'b0;
  logic [CW-1:0] count = '0;
  logic          rotate = 1'b0;
  logic [W-1:0]  q;
  logic          ser_out_r, ser_out_l, busy, done;

  shift_register_univ #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock(clock), .clear(clear), .enable(enable), .mode(mode),
    .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .par_in(par_in),
    .start(start), .dir(dir), .count(count),
`ifdef SHIFT_ROTATE_EN
    .rotate(rotate),
`endif
    .q(q), .ser_out_r(ser_out_r), .ser_out_l(ser_out_l), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  // Model: register value, shifts still owed, and a pending done pulse.
  int mq = 0, mleft = 0;
  bit mdone = 0, mdir = 0, mrot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mshift(input bit left, input bit rot);
    int b;
    if (left) begin
      b  = rot ? ((mq >> (W-1)) & 1) : int'(ser_in_l);
      mq = ((mq << 1) | b) & ((1 << W) - 1);
    end else begin
      b  = rot ? (mq & 1) : int'(ser_in_r);
      mq = (mq >> 1) | (b << (W-1));
    end
  endtask

  task automatic model_step();
    if (!enable) return;
    if (mdone) mdone = 0;
    else if (mleft > 0) begin
      mshift(mdir, mrot);
      mleft--;
      if (mleft == 0) mdone = 1;
    end else if (start) begin
      if (count != 0) begin mleft = int'(count); mdir = dir; mrot = rotate; end
      else mdone = 1;
    end else begin
      case (mode)
        2'b01: mshift(1'b0, rotate);
        2'b10: mshift(1'b1, rotate);
        2'b11: mq = int'(par_in);
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [W-1:0] eq, input logic eb, input logic ed);
    chk({nm, ".q"}, 32'(q), 32'(eq));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".done"}, 32'(done), 32'(ed));
  endtask

  typedef struct {
    logic [1:0]    md;
    logic          sir, sil;
    logic [W-1:0]  par;
    logic          st, dr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  eq;
    logic          eb, ed;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] md, input logic sir, input logic sil,
                              input logic [W-1:0] par, input logic st, input logic dr,
                              input logic [CW-1:0] cnt, input logic [W-1:0] eq,
                              input logic eb, input logic ed);
    vec_t v;
    v.md = md; v.sir = sir; v.sil = sil; v.par = par; v.st = st; v.dr = dr;
    v.cnt = cnt; v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  vec_t vt[20];

  initial begin
    vt[0]  = mk(2'b00, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    vt[1]  = mk(2'b11, 0, 0, 4'b1011, 0, 0, 0, 4'b1011, 0, 0);
    vt[2]  = mk(2'b01, 0, 0, 4'b0000, 0, 0, 0, 4'b0101, 0, 0);
    vt[3]  = mk(2'b10, 0, 1, 4'b0000, 0, 0, 0, 4'b1011, 0, 0);
    vt[4]  = mk(2'b11, 0, 0, 4'b0000, 1, 1, 3, 4'b1011, 1, 0);
    vt[5]  = mk(2'b11, 0, 0, 4'b0000, 0, 0, 0, 4'b0110, 1, 0);
    vt[6]  = mk(2'b11, 0, 0, 4'b0000, 0, 0, 0, 4'b1100, 1, 0);
    vt[7]  = mk(2'b11, 0, 0, 4'b0000, 0, 0, 0, 4'b1000, 0, 1);
    vt[8]  = mk(2'b11, 0, 0, 4'b0000, 0, 0, 0, 4'b1000, 0, 0);
    vt[9]  = mk(2'b11, 0, 0, 4'b0101, 1, 0, 0, 4'b1000, 0, 1);
    vt[10] = mk(2'b11, 0, 0, 4'b0101, 0, 0, 0, 4'b1000, 0, 0);
    vt[11] = mk(2'b11, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    vt[12] = mk(2'b00, 1, 0, 4'b0000, 1, 0, 6, 4'b0000, 1, 0);
    vt[13] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1000, 1, 0);
    vt[14] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1100, 1, 0);
    vt[15] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1110, 1, 0);
    vt[16] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 1, 0);
    vt[17] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 1, 0);
    vt[18] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 0, 1);
    vt[19] = mk(2'b00, 1, 0, 4'b0000, 0, 0, 0, 4'b1111, 0, 0);

    #12;
    chk_state("reset", 4'b0000, 0, 0);
    clear  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 20; i++) begin
      mode = vt[i].md; ser_in_r = vt[i].sir; ser_in_l = vt[i].sil; par_in = vt[i].par;
      start = vt[i].st; dir = vt[i].dr; count = vt[i].cnt;
      tick();
      chk_state($sformatf("vec%0d", i), vt[i].eq, vt[i].eb, vt[i].ed);
      chk($sformatf("vec%0d.sor", i), 32'(ser_out_r), 32'(vt[i].eq[0]));
      chk($sformatf("vec%0d.sol", i), 32'(ser_out_l), 32'(vt[i].eq[W-1]));
    end

    // Asynchronous abort mid-SHIFT.
    mode = 2'b11; par_in = 4'b1011; start = 0; tick();
    mode = 2'b00; start = 1; dir = 0; count = 5; ser_in_r = 1; tick();
    start = 0; tick();
    chk_state("pre_abort", 4'b1101, 1, 0);
    #3 clear = 1'b0;
    #1 chk_state("abort_async", 4'b0000, 0, 0);
    mq = 0; mleft = 0; mdone = 0;
    #2 clear = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_state($sformatf("post_abort%0d", i), 4'b0000, 0, 0);
    end

    // Stall mid-SHIFT, then let it finish; done holds across a stall.
    mode = 2'b11; par_in = 4'b1011; tick();
    chk_state("stall_load", 4'b1011, 0, 0);
    mode = 2'b00; start = 1; dir = 0; count = 4; ser_in_r = 0; tick();
    chk_state("stall_start", 4'b1011, 1, 0);
    start = 0; tick();
    chk_state("stall_sh1", 4'b0101, 1, 0);
    enable = 0; tick(); chk_state("stall_f0", 4'b0101, 1, 0);
    tick();             chk_state("stall_f1", 4'b0101, 1, 0);
    enable = 1; tick(); chk_state("stall_sh2", 4'b0010, 1, 0);
    tick();             chk_state("stall_sh3", 4'b0001, 1, 0);
    tick();             chk_state("stall_sh4", 4'b0000, 0, 1);
    enable = 0; tick(); chk_state("done_hold", 4'b0000, 0, 1);
    enable = 1; tick(); chk_state("done_clr", 4'b0000, 0, 0);

`ifdef SHIFT_ROTATE_EN
    mode = 2'b11; par_in = 4'b1001; tick();
    rotate = 1; ser_in_r = 0; ser_in_l = 0;
    mode = 2'b00; start = 1; dir = 0; count = 1; tick();
    chk_state("rot_start", 4'b1001, 1, 0);
    start = 0; rotate = 0; ser_in_r = 0; tick();
    chk_state("rot_auto", 4'b1100, 0, 1);
    tick();
    rotate = 1; mode = 2'b10; ser_in_l = 0; tick();
    chk_state("rot_manual", 4'b1001, 0, 0);
    rotate = 0; mode = 2'b00;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      mode     = 2'($urandom_range(0, 3));
      ser_in_r = 1'($urandom_range(0, 1));
      ser_in_l = 1'($urandom_range(0, 1));
      par_in   = W'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      dir      = 1'($urandom_range(0, 1));
      count    = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 1)) : CW'($urandom_range(2, 15));
`ifdef SHIFT_ROTATE_EN
      rotate   = 1'($urandom_range(0, 1));
`endif
      tick();
      chk($sformatf("rnd%0d.q", i), 32'(q), 32'(mq));
      chk($sformatf("rnd%0d.busy", i), 32'(busy), 32'(mleft > 0));
      chk($sformatf("rnd%0d.done", i), 32'(done), 32'(mdone));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
